// File: rtl/pkt_verdict_gate_pkg.sv
// Shared types for the packet verdict gate: FSM state encoding and the
// flattened AXI-Stream beat carried through the output register.
package pkt_filter_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int USER_W_DEF = 16;
    localparam int KEEP_W_DEF = DATA_W_DEF / 8;

    // IDLE means the next accepted beat is the first beat (SOP) of a packet.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } gate_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [KEEP_W_DEF-1:0] keep;
        logic                  last;
        logic [USER_W_DEF-1:0] user_size;
        logic [USER_W_DEF-1:0] user_src;
        logic [USER_W_DEF-1:0] user_dst;
    } axis_beat_t;

endpackage

// File: rtl/pkt_verdict_gate_if.sv
// AXI-Stream bundle with size/src/dst sideband, used for both the RX input
// and the C2H output of the verdict gate.
interface pkt_verdict_gate_if
    import pkt_filter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int USER_W = USER_W_DEF
);
    logic                tvalid;
    logic                tready;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic [USER_W-1:0]   tuser_size;
    logic [USER_W-1:0]   tuser_src;
    logic [USER_W-1:0]   tuser_dst;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst,
        output tready
    );
endinterface

// File: rtl/pkt_verdict_gate_axis_reg_slice.sv
// One-stage forward register for an AXI-Stream beat. The owner decides when
// a beat is loaded; the slice only holds it until downstream takes it.
module axis_reg_slice
    import pkt_filter_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_load,
    input  axis_beat_t i_beat,
    input  logic       i_ready,
    output logic       o_valid,
    output axis_beat_t o_beat
);
    logic       r_valid;
    axis_beat_t r_beat;

    // Load a new beat, otherwise retire the held one once downstream accepts it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            // NOTE: the payload is reset as well because the C2H side must read
            // all-zero data/sideband while in reset, not just tvalid=0.
            r_beat  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_beat  <= i_beat;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_beat  = r_beat;
endmodule

// File: rtl/pkt_verdict_gate.sv
// Packet-granular pass/drop gate: the verdict seen on SOP is held to TLAST,
// so each packet is forwarded or sunk whole. Registered output, 1 beat/cycle.
module pkt_verdict_gate
    import pkt_filter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int USER_W = USER_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                verdict_pass,
    input  logic                stats_clr,
    pkt_verdict_gate_if.slave   s_axis,
    pkt_verdict_gate_if.master  m_axis,
    output logic [CNT_W-1:0]    pkt_pass_cnt,
    output logic [CNT_W-1:0]    pkt_drop_cnt,
    output logic                in_pkt
);
    gate_state_t      r_state;
    gate_state_t      w_next_state;
    logic             w_sink;
    logic             w_out_free;
    logic             w_accept;
    logic             w_fwd;
    logic             w_out_valid;
    axis_beat_t       w_in_beat;
    axis_beat_t       w_out_beat;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    // Decide whether the current beat is being sunk: held DROP, or an SOP with a fail verdict.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        w_sink = 1'b0;
        case (r_state)
            IDLE:    w_sink = !verdict_pass;
            DROP:    w_sink = 1'b1;
            default: w_sink = 1'b0;
        endcase
    end

    // Sinking never waits on C2H, so a drop cannot stall or bubble the output.
    assign w_out_free    = !w_out_valid || m_axis.tready;
    assign s_axis.tready = rstn && (w_sink || w_out_free);
    assign w_accept      = s_axis.tvalid && s_axis.tready;
    assign w_fwd         = w_accept && !w_sink;

    // Next-state: SOP picks PASS/DROP unless it is also TLAST; any TLAST returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (!s_axis.tlast) w_next_state = verdict_pass ? PASS : DROP;
                end
                PASS, DROP: begin
                    if (s_axis.tlast) w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // State register; reset abandons any partial packet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Pack the incoming beat for the output register.
    always_comb begin
        w_in_beat           = '0;
        w_in_beat.data      = s_axis.tdata[DATA_W-1:0];
        w_in_beat.keep      = s_axis.tkeep[DATA_W/8-1:0];
        w_in_beat.last      = s_axis.tlast;
        w_in_beat.user_size = s_axis.tuser_size[USER_W-1:0];
        w_in_beat.user_src  = s_axis.tuser_src[USER_W-1:0];
        w_in_beat.user_dst  = s_axis.tuser_dst[USER_W-1:0];
    end

    axis_reg_slice u_out_slice (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_fwd),
        .i_beat  (w_in_beat),
        .i_ready (m_axis.tready),
        .o_valid (w_out_valid),
        .o_beat  (w_out_beat)
    );

    assign m_axis.tvalid     = w_out_valid;
    assign m_axis.tdata      = w_out_beat.data;
    assign m_axis.tkeep      = w_out_beat.keep;
    assign m_axis.tlast      = w_out_beat.last;
    assign m_axis.tuser_size = w_out_beat.user_size;
    assign m_axis.tuser_src  = w_out_beat.user_src;
    assign m_axis.tuser_dst  = w_out_beat.user_dst;

    // Count packets at TLAST acceptance; a clear overrides a coincident increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (stats_clr) begin
            r_pass_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (w_accept && s_axis.tlast) begin
            if (w_sink) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            else        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
        end
    end

    assign pkt_pass_cnt = r_pass_cnt;
    assign pkt_drop_cnt = r_drop_cnt;
    assign in_pkt       = (r_state != IDLE);
endmodule

// File: tb/tb_pkt_verdict_gate.sv
// Directed bench for pkt_verdict_gate: whole-packet pass/drop, output
// latency, back-pressure, sinking under stall, counters and mid-packet reset.
module tb_pkt_verdict_gate;
    localparam int DW = 512;
    localparam int UW = 16;
    localparam int CW = 32;

    logic          clk          = 1'b0;
    logic          rstn         = 1'b1;
    logic          verdict_pass = 1'b0;
    logic          stats_clr    = 1'b0;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] drop_cnt;
    logic          in_pkt;
    logic          kz           = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    pkt_verdict_gate_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    pkt_verdict_gate_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    pkt_verdict_gate #(.DATA_W(DW), .USER_W(UW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .verdict_pass (verdict_pass),
        .stats_clr    (stats_clr),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .pkt_pass_cnt (pass_cnt),
        .pkt_drop_cnt (drop_cnt),
        .in_pkt       (in_pkt)
    );

    always #2 clk = ~clk;

    // Record every output beat that will be taken at the next rising edge.
    always @(negedge clk) begin
        if (rstn && m_if.tvalid && m_if.tready)
            got_q.push_back({m_if.tlast, m_if.tdata[DW-1:DW-16], m_if.tdata[15:0]});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [15:0] tag, input logic last, input logic verdict);
        s_if.tvalid     = 1'b1;
        s_if.tdata      = {32{tag}};
        s_if.tkeep      = kz ? '0 : '1;
        s_if.tlast      = last;
        s_if.tuser_size = 16'd64;
        s_if.tuser_src  = tag;
        s_if.tuser_dst  = ~tag;
        verdict_pass    = verdict;
    endtask

    task automatic idle();
        s_if.tvalid  = 1'b0;
        s_if.tlast   = 1'b0;
        verdict_pass = 1'b0;
    endtask

    // Present one beat and hold it until accepted; fwd says whether it must reach C2H.
    task automatic send(input logic [15:0] tag, input logic last, input logic verdict,
                        input logic fwd, output int waits);
        drive_beat(tag, last, verdict);
        waits = 0;
        @(negedge clk);
        while (!s_if.tready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!s_if.tready) check("send_timeout", s_if.tready, 1'b1);
        @(posedge clk);
        #1;
        if (fwd) exp_q.push_back({last, tag, tag});
    endtask

    task automatic compare_q(input string tag);
        int n;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_beat"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_stats();
        stats_clr = 1'b1;
        wait_cycle();
        stats_clr = 1'b0;
    endtask

    initial begin
        int w;
        int wsum;
        int idle_viol;
        logic [15:0] tag;

        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
        s_if.tuser_size = '0; s_if.tuser_src = '0; s_if.tuser_dst = '0;
        m_if.tready = 1'b1;

        // Reset state
        #1 rstn = 1'b0;
        repeat (3) wait_cycle();
        check("rst_m_tvalid", m_if.tvalid, 1'b0);
        check("rst_m_tdata", m_if.tdata, '0);
        check("rst_m_tlast", m_if.tlast, 1'b0);
        check("rst_m_tuser_src", m_if.tuser_src, '0);
        check("rst_pass_cnt", pass_cnt, '0);
        check("rst_drop_cnt", drop_cnt, '0);
        check("rst_in_pkt", in_pkt, 1'b0);
        check("rst_s_tready", s_if.tready, 1'b0);
        rstn = 1'b1;
        wait_cycle();

        // 1: three 4-beat packets, verdicts 1,0,1, no back-pressure
        wsum = 0;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                tag = {8'(p + 1), 8'(b)};
                send(tag, b == 3, p != 1, p != 1, w);
                wsum += w;
                if (p == 0 && b == 0) begin
                    check("t1_latency_tvalid", m_if.tvalid, 1'b1);
                    check("t1_latency_tdata", m_if.tdata, {32{16'h0100}});
                    check("t1_latency_tuser_src", m_if.tuser_src, 16'h0100);
                end
                if (p == 1 && b == 1) check("t1_in_pkt_drop", in_pkt, 1'b1);
            end
        end
        idle();
        repeat (2) wait_cycle();
        check("t1_waits", wsum, 0);
        compare_q("t1");
        check("t1_pass_cnt", pass_cnt, 2);
        check("t1_drop_cnt", drop_cnt, 1);

        // 2: verdict toggling during a 6-beat passing packet, one beat with all-zero tkeep
        clear_stats();
        check("t2_clr_pass", pass_cnt, 0);
        wsum = 0;
        for (int b = 0; b < 6; b++) begin
            kz = (b == 2);
            send({8'h20, 8'(b)}, b == 5, (b % 2) == 0, 1'b1, w);
            wsum += w;
        end
        kz = 1'b0;
        idle();
        repeat (2) wait_cycle();
        check("t2_waits", wsum, 0);
        compare_q("t2");
        check("t2_pass_cnt", pass_cnt, 1);
        check("t2_drop_cnt", drop_cnt, 0);

        // 3: 5-cycle C2H stall in the middle of an 8-beat passing packet
        clear_stats();
        for (int b = 0; b < 3; b++) send({8'h30, 8'(b)}, 1'b0, 1'b1, 1'b1, w);
        m_if.tready = 1'b0;
        drive_beat(16'h3003, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            wait_cycle();
            check("t3_stall_s_tready", s_if.tready, 1'b0);
            check("t3_stall_m_tdata", m_if.tdata, {32{16'h3002}});
        end
        check("t3_stall_m_tvalid", m_if.tvalid, 1'b1);
        m_if.tready = 1'b1;
        wsum = 0;
        for (int b = 3; b < 8; b++) begin
            send({8'h30, 8'(b)}, b == 7, 1'b0, 1'b1, w);
            wsum += w;
        end
        idle();
        repeat (2) wait_cycle();
        check("t3_resume_waits", wsum, 0);
        compare_q("t3");
        check("t3_pass_cnt", pass_cnt, 1);

        // 4: 3-beat drop while a forwarded beat is stalled on the output
        clear_stats();
        m_if.tready = 1'b0;
        send(16'h4000, 1'b1, 1'b1, 1'b1, w);
        check("t4_held_load_waits", w, 0);
        wsum = 0;
        for (int b = 0; b < 3; b++) begin
            send({8'h41, 8'(b)}, b == 2, b != 0, 1'b0, w);
            wsum += w;
        end
        idle();
        check("t4_sink_waits", wsum, 0);
        check("t4_held_tvalid", m_if.tvalid, 1'b1);
        check("t4_held_tdata", m_if.tdata, {32{16'h4000}});
        check("t4_held_tlast", m_if.tlast, 1'b1);
        check("t4_drop_cnt", drop_cnt, 1);
        check("t4_pass_cnt", pass_cnt, 1);
        check("t4_nothing_out_yet", got_q.size(), 0);
        m_if.tready = 1'b1;
        repeat (2) wait_cycle();
        compare_q("t4");

        // 5: 100 single-beat packets, alternating verdict 1/0
        clear_stats();
        wsum = 0;
        idle_viol = 0;
        for (int i = 0; i < 100; i++) begin
            send(16'h5000 + 16'(i), 1'b1, (i % 2) == 0, (i % 2) == 0, w);
            wsum += w;
            if (in_pkt !== 1'b0) idle_viol++;
        end
        idle();
        repeat (2) wait_cycle();
        check("t5_in_pkt_seen", idle_viol, 0);
        check("t5_waits", wsum, 0);
        check("t5_pass_cnt", pass_cnt, 50);
        check("t5_drop_cnt", drop_cnt, 50);
        compare_q("t5");

        // 6: reset mid-DROP with a stalled output beat, then a clean 2-beat packet
        clear_stats();
        m_if.tready = 1'b0;
        send(16'h6000, 1'b1, 1'b1, 1'b0, w);  // held beat is discarded by the reset below
        send(16'h6100, 1'b0, 1'b0, 1'b0, w);
        send(16'h6101, 1'b0, 1'b0, 1'b0, w);
        check("t6_in_pkt_before_rst", in_pkt, 1'b1);
        check("t6_pass_before_rst", pass_cnt, 1);
        idle();
        #1 rstn = 1'b0;
        #1;
        check("t6_rst_m_tvalid", m_if.tvalid, 1'b0);
        check("t6_rst_s_tready", s_if.tready, 1'b0);
        check("t6_rst_in_pkt", in_pkt, 1'b0);
        check("t6_rst_pass_cnt", pass_cnt, 0);
        repeat (2) wait_cycle();
        rstn = 1'b1;
        m_if.tready = 1'b1;
        wait_cycle();
        send(16'h6200, 1'b0, 1'b1, 1'b1, w);
        send(16'h6201, 1'b1, 1'b0, 1'b1, w);
        idle();
        repeat (2) wait_cycle();
        compare_q("t6");
        check("t6_pass_cnt", pass_cnt, 1);
        check("t6_drop_cnt", drop_cnt, 0);
        send(16'h6300, 1'b0, 1'b1, 1'b1, w);
        stats_clr = 1'b1;
        send(16'h6301, 1'b1, 1'b0, 1'b1, w);
        stats_clr = 1'b0;
        idle();
        check("t6_clr_vs_tlast", pass_cnt, 0);
        repeat (2) wait_cycle();
        compare_q("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
